// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings shared by the ALU datapath and its wrapper
package alu_pkg;

   // Four-bit operation selects; shift codes only decode when ALU_SHIFT_EN is defined
   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_OR  = 4'b0001,
      OP_ADD = 4'b0010,
      OP_SUB = 4'b0110,
      OP_SLT = 4'b0111,
      OP_SLL = 4'b1000,
      OP_SRL = 4'b1001,
      OP_SRA = 4'b1010,
      OP_NOR = 4'b1100
   } alu_op_e;

endpackage

// File: rtl/alu_datapath.sv
// rtl/alu_datapath.sv - combinational ALU result and signed-overflow (shifts gated by ALU_SHIFT_EN)
module alu_datapath
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             add_ovf;
   logic             sub_ovf;
   logic             lt;

   assign sum  = a + b;
   assign diff = a - b;

   // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips away from a
   assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
   assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

   // Signed less-than stays correct when a-b wraps: correct the difference sign with the overflow
   assign lt = diff[WIDTH-1] ^ sub_ovf;

`ifdef ALU_SHIFT_EN
   localparam int SHW = $clog2(WIDTH);
   logic [SHW-1:0] shamt;
   assign shamt = b[SHW-1:0];
`endif

   // Opcode decode; anything not decoded falls through to zero result and no overflow
   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (op)
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_ADD: begin
            result   = sum;
            overflow = add_ovf;
         end
         OP_SUB: begin
            result   = diff;
            overflow = sub_ovf;
         end
         OP_SLT: result = {{(WIDTH-1){1'b0}}, lt};
         OP_NOR: result = ~(a | b);
`ifdef ALU_SHIFT_EN
         OP_SLL: result = a << shamt;
         OP_SRL: result = a >> shamt;
         OP_SRA: result = $signed(a) >>> shamt;
`endif
         default: begin
            result   = '0;
            overflow = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_core.sv
// rtl/alu_core.sv - single-cycle registered ALU top (shift opcodes enabled by ALU_SHIFT_EN)
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALUOperation,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic             Overflow,
   output logic             out_valid
);

   logic [WIDTH-1:0] dp_result;
   logic             dp_overflow;

   alu_datapath #(
      .WIDTH(WIDTH)
   ) u_datapath (
      .a        (A),
      .b        (B),
      .op       (ALUOperation),
      .result   (dp_result),
      .overflow (dp_overflow)
   );

   // Capture the datapath on each accepted operation; results hold while in_valid is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ALUResult <= '0;
         Zero      <= 1'b1;
         Overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            ALUResult <= dp_result;
            Zero      <= (dp_result == '0);
            Overflow  <= dp_overflow;
         end
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - randomized and directed self-checking bench for alu_core
module tb_alu_core;

   localparam int W = 32;

   logic         clk      = 1'b0;
   logic         rst_n    = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] a        = '0;
   logic [W-1:0] b        = '0;
   logic [3:0]   op       = 4'b0000;
   logic [W-1:0] res;
   logic         zero;
   logic         ovf;
   logic         ovalid;

   int n_cmp = 0;
   int n_err = 0;
   bit checking = 1'b0;

   alu_core #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .A            (a),
      .B            (b),
      .ALUOperation (op),
      .ALUResult    (res),
      .Zero         (zero),
      .Overflow     (ovf),
      .out_valid    (ovalid)
   );

   always #5 clk = ~clk;

   // Reference result from signed integer arithmetic on widened operands
   function automatic logic [W-1:0] model_res(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] o);
      longint sx, sy, full;
      int sh;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      sh = int'(y[$clog2(W)-1:0]);
      model_res = '0;
      case (o)
         4'b0000: model_res = x & y;
         4'b0001: model_res = x | y;
         4'b0010: begin full = sx + sy; model_res = full[W-1:0]; end
         4'b0110: begin full = sx - sy; model_res = full[W-1:0]; end
         4'b0111: model_res = (sx < sy) ? W'(1) : W'(0);
         4'b1100: model_res = ~(x | y);
`ifdef ALU_SHIFT_EN
         4'b1000: model_res = x << sh;
         4'b1001: model_res = x >> sh;
         4'b1010: model_res = $signed(x) >>> sh;
`endif
         default: model_res = '0;
      endcase
   endfunction

   // Reference overflow: the exact signed sum/difference falls outside the W-bit signed range
   function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] o);
      longint sx, sy, full, maxs, mins;
      sx   = longint'($signed(x));
      sy   = longint'($signed(y));
      maxs = (longint'(1) <<< (W - 1)) - 1;
      mins = -(longint'(1) <<< (W - 1));
      model_ovf = 1'b0;
      if (o == 4'b0010 || o == 4'b0110) begin
         full = (o == 4'b0010) ? sx + sy : sx - sy;
         model_ovf = (full > maxs) || (full < mins);
      end
   endfunction

   logic [W-1:0] m_res;
   logic         m_zero;
   logic         m_ovf;
   logic         m_valid;

   // Expected registered outputs
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_res   <= '0;
         m_zero  <= 1'b1;
         m_ovf   <= 1'b0;
         m_valid <= 1'b0;
      end else begin
         m_valid <= in_valid;
         if (in_valid) begin
            m_res  <= model_res(a, b, op);
            m_zero <= (model_res(a, b, op) == '0);
            m_ovf  <= model_ovf(a, b, op);
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every cycle after the first edge: DUT against the model
   always @(negedge clk) begin
      if (checking) begin
         chk("cmp out_valid", 64'(ovalid), 64'(m_valid));
         chk("cmp ALUResult", 64'(res), 64'(m_res));
         chk("cmp Zero", 64'(zero), 64'(m_zero));
         chk("cmp Overflow", 64'(ovf), 64'(m_ovf));
      end
   end

   // One accepted operation with hand-computed expectations for both DUT and model
   task automatic lit(input string nm, input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] o,
                      input logic [W-1:0] er, input logic ez, input logic eo);
      @(negedge clk);
      a = x; b = y; op = o; in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk({nm, " result"}, 64'(res), 64'(er));
      chk({nm, " zero"}, 64'(zero), 64'(ez));
      chk({nm, " overflow"}, 64'(ovf), 64'(eo));
      chk({nm, " out_valid"}, 64'(ovalid), 64'(1'b1));
      chk({nm, " model result"}, 64'(model_res(x, y, o)), 64'(er));
      chk({nm, " model overflow"}, 64'(model_ovf(x, y, o)), 64'(eo));
   endtask

   function automatic logic [W-1:0] pick_operand();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
         0: v = '0;
         1: v = '1;
         2: v = {1'b1, {(W-1){1'b0}}};
         3: v = {1'b0, {(W-1){1'b1}}};
         4: v = W'(1);
         default: v = W'($urandom());
      endcase
      return v;
   endfunction

   initial begin
      @(posedge clk);
      #1;
      chk("reset result", 64'(res), 64'(0));
      chk("reset zero", 64'(zero), 64'(1));
      chk("reset overflow", 64'(ovf), 64'(0));
      chk("reset out_valid", 64'(ovalid), 64'(0));
      checking = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      lit("AND", 32'hFFFFFFFF, 32'h00000000, 4'b0000, 32'h00000000, 1'b1, 1'b0);
      lit("OR", 32'hFFFFFFFF, 32'h00000000, 4'b0001, 32'hFFFFFFFF, 1'b0, 1'b0);
      lit("ADD 1+1", 32'h1, 32'h1, 4'b0010, 32'h00000002, 1'b0, 1'b0);

      // Idle cycle: outputs hold the last ADD result
      @(negedge clk);
      in_valid = 1'b0; a = 32'h12345678; b = 32'h9ABCDEF0; op = 4'b0001;
      @(posedge clk);
      #1;
      chk("hold result", 64'(res), 64'(32'h2));
      chk("hold out_valid", 64'(ovalid), 64'(0));

      lit("ADD ovf", 32'h7FFFFFFF, 32'h1, 4'b0010, 32'h80000000, 1'b0, 1'b1);
      lit("SUB 2-1", 32'h2, 32'h1, 4'b0110, 32'h00000001, 1'b0, 1'b0);
      lit("SUB ovf", 32'h80000000, 32'h1, 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b1);
      lit("SLT 1,2", 32'h1, 32'h2, 4'b0111, 32'h00000001, 1'b0, 1'b0);
      lit("SLT neg", 32'h80000000, 32'h1, 4'b0111, 32'h00000001, 1'b0, 1'b0);
      lit("SLT wrap", 32'h7FFFFFFF, 32'h80000000, 4'b0111, 32'h00000000, 1'b1, 1'b0);
      lit("SLT 2,1", 32'h2, 32'h1, 4'b0111, 32'h00000000, 1'b1, 1'b0);
      lit("NOR", 32'hFFFFFFFF, 32'h0, 4'b1100, 32'h00000000, 1'b1, 1'b0);
      lit("NOR 0", 32'h0, 32'h0, 4'b1100, 32'hFFFFFFFF, 1'b0, 1'b0);
      lit("op 1111", 32'h0, 32'h0, 4'b1111, 32'h00000000, 1'b1, 1'b0);
`ifdef ALU_SHIFT_EN
      lit("SRA", 32'h80000000, 32'h4, 4'b1010, 32'hF8000000, 1'b0, 1'b0);
      lit("SRL", 32'h80000000, 32'h4, 4'b1001, 32'h08000000, 1'b0, 1'b0);
      lit("SLL", 32'h00000003, 32'h21, 4'b1000, 32'h00000006, 1'b0, 1'b0);
`else
      lit("SRA off", 32'h80000000, 32'h4, 4'b1010, 32'h00000000, 1'b1, 1'b0);
`endif
      lit("ADD ovf again", 32'h7FFFFFFF, 32'h1, 4'b0010, 32'h80000000, 1'b0, 1'b1);

      // Reset mid-stream while an operation is offered: outputs clear at once, op discarded
      @(negedge clk);
      a = 32'h5; b = 32'h6; op = 4'b0010; in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset result", 64'(res), 64'(0));
      chk("async reset zero", 64'(zero), 64'(1));
      chk("async reset overflow", 64'(ovf), 64'(0));
      chk("async reset out_valid", 64'(ovalid), 64'(0));
      @(posedge clk);
      #1;
      chk("reset discard result", 64'(res), 64'(0));
      chk("reset discard out_valid", 64'(ovalid), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      a = 32'h1; b = 32'h1; op = 4'b0010; in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("first after reset result", 64'(res), 64'(2));
      chk("first after reset out_valid", 64'(ovalid), 64'(1));

      // Randomized traffic checked every cycle by the compare process
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         in_valid = ($urandom_range(0, 3) != 0);
         a = pick_operand();
         b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2 * W)) : pick_operand();
         op = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      checking = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
